// File: rtl/simple_spi_master.sv
// simple_spi_master: single-word SPI master, mode 0, MSB first.
// Ports: system_clk, reset (async, active-high), start/value_mosi in,
//        value_miso/busy/done out, pin_ncs/pin_clk/pin_mosi out, pin_miso in.
module simple_spi_master #(
    parameter int WIDTH       = 8,
    parameter int HALF_PERIOD = 4,
    parameter int CS_GAP      = 4
) (
    input  logic             system_clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] value_mosi,
    output logic [WIDTH-1:0] value_miso,
    output logic             busy,
    output logic             done,
    output logic             pin_ncs,
    output logic             pin_clk,
    output logic             pin_mosi,
    input  logic             pin_miso
);

    localparam int HW = $clog2(HALF_PERIOD);
    localparam int GW = $clog2(CS_GAP + 1);
    localparam int BW = $clog2(WIDTH + 1);

    localparam logic [HW-1:0] HP_LAST  = HW'(HALF_PERIOD - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        GAP
    } state_t;

    state_t           state;
    logic [HW-1:0]    hcnt;
    logic [GW-1:0]    gcnt;
    logic [BW-1:0]    bcnt;
    logic [WIDTH-1:0] tx_sr;
    logic [WIDTH-1:0] rx_sr;
    logic             last;

    logic hp_end;
    assign hp_end = (hcnt == HP_LAST);

    always_ff @(posedge system_clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            hcnt       <= '0;
            gcnt       <= '0;
            bcnt       <= '0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            last       <= 1'b0;
            value_miso <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pin_ncs    <= 1'b1;
            pin_clk    <= 1'b0;
            pin_mosi   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        tx_sr    <= value_mosi;
                        pin_mosi <= value_mosi[WIDTH-1];
                        pin_ncs  <= 1'b0;
                        busy     <= 1'b1;
                        hcnt     <= '0;
                        bcnt     <= '0;
                        last     <= 1'b0;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (hp_end) begin
                        hcnt    <= '0;
                        pin_clk <= 1'b1;
                        state   <= HIGH;
                    end else begin
                        hcnt <= hcnt + 1'b1;
                    end
                end
                HIGH: begin
                    if (hp_end) begin
                        hcnt    <= '0;
                        pin_clk <= 1'b0;
                        // Sample at the very end of the high phase.
                        rx_sr   <= {rx_sr[WIDTH-2:0], pin_miso};
                        bcnt    <= bcnt + 1'b1;
                        if (bcnt == LAST_BIT) begin
                            // Keep the last bit on MOSI through the final low phase.
                            last <= 1'b1;
                        end else begin
                            tx_sr    <= {tx_sr[WIDTH-2:0], 1'b0};
                            pin_mosi <= tx_sr[WIDTH-2];
                        end
                        state <= LOW;
                    end else begin
                        hcnt <= hcnt + 1'b1;
                    end
                end
                LOW: begin
                    if (hp_end) begin
                        hcnt <= '0;
                        if (last) begin
                            pin_ncs    <= 1'b1;
                            pin_mosi   <= 1'b0;
                            value_miso <= rx_sr;
                            done       <= 1'b1;
                            gcnt       <= '0;
                            last       <= 1'b0;
                            state      <= GAP;
                        end else begin
                            pin_clk <= 1'b1;
                            state   <= HIGH;
                        end
                    end else begin
                        hcnt <= hcnt + 1'b1;
                    end
                end
                GAP: begin
                    if (gcnt == GAP_LAST) begin
                        gcnt  <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        gcnt <= gcnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_simple_spi_master.sv
// tb_simple_spi_master: randomized bench for simple_spi_master with a
// cycle-offset reference model and a pin-level behavioural slave.
module tb_simple_spi_master;

    localparam int W = 8;
    localparam int H = 4;
    localparam int G = 4;
    localparam int T = 1 + H * (2 * W + 1);

    logic         system_clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] value_mosi;
    logic [W-1:0] value_miso;
    logic         busy;
    logic         done;
    logic         pin_ncs;
    logic         pin_clk;
    logic         pin_mosi;
    logic         pin_miso;

    simple_spi_master #(.WIDTH(W), .HALF_PERIOD(H), .CS_GAP(G)) dut (
        .system_clk(system_clk),
        .reset(reset),
        .start(start),
        .value_mosi(value_mosi),
        .value_miso(value_miso),
        .busy(busy),
        .done(done),
        .pin_ncs(pin_ncs),
        .pin_clk(pin_clk),
        .pin_mosi(pin_mosi),
        .pin_miso(pin_miso)
    );

    always #5 system_clk = ~system_clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural slave ----------------
    logic         loop;
    logic [W-1:0] slave_word;
    logic         s_out = 1'b0;
    int           s_bit = 0;
    int           s_cnt = 0;
    logic [W-1:0] s_rx = '0;

    assign pin_miso = loop ? pin_mosi : s_out;

    always @(negedge pin_ncs) begin
        s_cnt = 0;
        s_rx  = '0;
        s_out = slave_word[W-1];
        s_bit = W - 2;
    end

    always @(negedge pin_clk) begin
        if (!pin_ncs && s_bit >= 0) begin
            s_out = slave_word[s_bit];
            s_bit--;
        end
    end

    always @(posedge pin_clk) begin
        if (!pin_ncs) begin
            s_rx = {s_rx[W-2:0], pin_mosi};
            s_cnt++;
        end
    end

    // ---------------- reference model ----------------
    function automatic logic m_clk(input int d);
        return (d >= 1 + H) && (d < 1 + 2 * H * W) && (((d - 1 - H) / H) % 2 == 0);
    endfunction

    function automatic logic m_mosi(input int d, input logic [W-1:0] w);
        int idx;
        if (d < 1 || d >= T) return 1'b0;
        idx = (d - 1) / (2 * H);
        if (idx > W - 1) idx = W - 1;
        return w[W-1-idx];
    endfunction

    int           cyc = 0;
    bit           active = 0;
    int           c0 = 0;
    logic [W-1:0] word_tx = '0;
    logic [W-1:0] exp_rx = '0;
    logic [W-1:0] mv = '0;
    int           accepts = 0;
    bit           m_inflight = 0;
    int           m_d = 0;

    // observations of the DUT used by directed checks
    logic prev_clk = 0, prev_ncs = 1, prev_mosi = 0, prev_busy = 0;
    int   edges = 0;
    int   busy_run = 0, busy_last = 0;
    int   done_d = 0, done_pulses = 0, ncs_falls = 0;
    logic [W-1:0] rxq[$];
    int   nfq[$];

    always @(negedge system_clk) begin
        int d;
        logic e_ncs, e_clk, e_mosi, e_busy, e_done;
        if (reset) begin
            active = 0;
            mv     = '0;
            e_ncs = 1; e_clk = 0; e_mosi = 0; e_busy = 0; e_done = 0;
            edges = 0;
            busy_run = 0;
        end else begin
            d      = active ? cyc - c0 : -1;
            e_ncs  = !(active && d >= 1 && d < T);
            e_clk  = active ? m_clk(d) : 1'b0;
            e_mosi = active ? m_mosi(d, word_tx) : 1'b0;
            e_busy = active && d >= 1 && d < T + G;
            e_done = active && d == T;
            if (e_done) mv = exp_rx;
        end
        chk("pin_ncs", pin_ncs, e_ncs);
        chk("pin_clk", pin_clk, e_clk);
        chk("pin_mosi", pin_mosi, e_mosi);
        chk("busy", busy, e_busy);
        chk("done", done, e_done);
        chk("value_miso", value_miso, mv);

        if (!reset) begin
            if (pin_clk && !prev_clk && !pin_ncs) edges++;
            if (pin_ncs != prev_ncs) chk("clk_at_ncs_edge", pin_clk, 1'b0);
            if (pin_clk && prev_clk) chk("mosi_stable_high", pin_mosi, prev_mosi);
            if (!pin_ncs && prev_ncs) begin
                ncs_falls++;
                nfq.push_back(cyc);
            end
            if (busy) busy_run++;
            if (prev_busy && !busy) begin
                busy_last = busy_run;
                busy_run  = 0;
            end
            if (done) begin
                done_pulses++;
                done_d = cyc - c0;
                rxq.push_back(value_miso);
                chk("edges_per_word", edges, W);
                chk("slave_rx", s_rx, word_tx);
                chk("slave_bits", s_cnt, W);
                edges = 0;
            end
        end
        prev_clk  = pin_clk;
        prev_ncs  = pin_ncs;
        prev_mosi = pin_mosi;
        prev_busy = busy;

        if (!reset && start && !(active && (cyc - c0) < T + G)) begin
            active  = 1;
            c0      = cyc;
            word_tx = value_mosi;
            exp_rx  = loop ? value_mosi : slave_word;
            accepts++;
        end
        m_inflight = active && (cyc - c0) < T + G;
        m_d        = active ? cyc - c0 : 0;
        cyc++;
    end

    // ---------------- stimulus ----------------
    task automatic wait_accepts(input int target);
        int k = 0;
        while (accepts < target && k < 300) begin
            @(posedge system_clk);
            k++;
        end
        #1;
        if (accepts < target) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got %0d expected %0d", accepts, target);
        end
    endtask

    task automatic wait_idle(input bit noise);
        int k = 0;
        while (m_inflight && k < 300) begin
            @(posedge system_clk);
            #1;
            k++;
            if (noise) begin
                value_mosi = W'($urandom);
                start = (m_d < T - 4) && ($urandom_range(0, 7) == 0);
            end
        end
        start = 0;
        if (m_inflight) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got busy expected idle");
        end
    endtask

    task automatic send(input logic [W-1:0] w);
        int a = accepts;
        @(posedge system_clk);
        #1;
        start      = 1;
        value_mosi = w;
        wait_accepts(a + 1);
        start = 0;
    endtask

    initial begin
        int a, nf, dp;
        reset      = 1;
        start      = 0;
        value_mosi = '0;
        loop       = 0;
        slave_word = '0;
        repeat (3) @(posedge system_clk);
        #1 reset = 0;
        repeat (50) @(posedge system_clk);
        #1;
        chk("idle_no_ncs_activity", ncs_falls, 0);

        // single word against a slave returning 0xA5
        loop       = 0;
        slave_word = 8'hA5;
        send(8'h3C);
        wait_idle(0);
        repeat (2) @(posedge system_clk);
        #1;
        chk("lit_done_cycle", done_d, 69);
        chk("lit_value_miso", value_miso, 8'hA5);
        chk("lit_slave_rx", s_rx, 8'h3C);
        chk("lit_busy_cycles", busy_last, 72);

        // back-to-back with start held high, loopback
        loop = 1;
        rxq.delete();
        nfq.delete();
        a = accepts;
        @(posedge system_clk);
        #1;
        start      = 1;
        value_mosi = 8'h00;
        wait_accepts(a + 1);
        value_mosi = 8'hFF;
        wait_accepts(a + 2);
        value_mosi = 8'h81;
        wait_accepts(a + 3);
        start = 0;
        wait_idle(0);
        repeat (2) @(posedge system_clk);
        #1;
        chk("b2b_count", rxq.size(), 3);
        if (rxq.size() == 3) begin
            chk("b2b_rx0", rxq[0], 8'h00);
            chk("b2b_rx1", rxq[1], 8'hFF);
            chk("b2b_rx2", rxq[2], 8'h81);
        end
        if (nfq.size() >= 2) chk("b2b_period", nfq[1] - nfq[0], 73);

        // ignored start during a busy transfer
        nf = ncs_falls;
        send(8'hC3);
        repeat (10) @(posedge system_clk);
        #1;
        start      = 1;
        value_mosi = 8'h55;
        @(posedge system_clk);
        #1;
        start = 0;
        wait_idle(0);
        repeat (2) @(posedge system_clk);
        #1;
        chk("ignored_start_txns", ncs_falls - nf, 1);
        chk("ignored_start_word", value_miso, 8'hC3);

        // reset in the middle of a word
        dp = done_pulses;
        send(8'h9E);
        repeat (19) @(posedge system_clk);
        #1 reset = 1;
        #2;
        chk("midreset_ncs", pin_ncs, 1'b1);
        chk("midreset_clk", pin_clk, 1'b0);
        repeat (2) @(posedge system_clk);
        #1 reset = 0;
        chk("midreset_no_done", done_pulses, dp);
        send(8'h12);
        wait_idle(0);
        repeat (2) @(posedge system_clk);
        #1;
        chk("post_reset_word", value_miso, 8'h12);

        // randomized words, modes and start noise
        for (int i = 0; i < 24; i++) begin
            loop       = ($urandom_range(0, 1) == 1);
            slave_word = W'($urandom);
            repeat ($urandom_range(0, 5)) @(posedge system_clk);
            send(W'($urandom));
            wait_idle(1);
        end
        repeat (5) @(posedge system_clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
